ha_selftest: RTL and testbench

- On-chip self-test sequencer for a half adder. It is the checking end of the half-adder stimulus flow: it drives the four input vectors into a half adder and samples the sum and carry that come back.
- Each result is compared against a golden model. The block accumulates an error count and per-vector fail flags, then reports pass or fail.
- Sits beside the half adder, with its own clock, for power-on or bench self-check.

---
 rtl/ha_selftest_if.sv | 26 ++
 rtl/ha_selftest.sv | 170 +++++++++++++++++
 tb/tb_ha_selftest.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ha_selftest_if.sv
// Signal bundle between the half-adder self-test sequencer and its environment:
// run control, status/results, and the drive/return link to the half adder.
interface ha_selftest_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             a_out;
    logic             b_out;
    logic             sum_in;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       fail_vec;

    modport master (
        input  start, sum_in, carry_in,
        output a_out, b_out, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, sum_in, carry_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/ha_selftest.sv
// Self-test sequencer for a half adder: sweeps the four input vectors, checks
// sum/carry against the golden half-adder function and reports pass/fail.
module ha_selftest #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ha_selftest_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PASS_LAST   = PC_W'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t           state_r, state_s;
    logic [1:0]       vec_r, vec_s;
    logic [PC_W-1:0]  pass_cnt_r, pass_cnt_s;
    logic [CNT_W-1:0] settle_cnt_r, settle_cnt_s;
    logic             a_r, a_s;
    logic             b_r, b_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    logic [ERR_W-1:0] err_r, err_s;
    logic [3:0]       fail_r, fail_s;

    logic             mism_s;
    logic [ERR_W-1:0] err_upd_s;
    logic [3:0]       fail_upd_s;
    logic [1:0]       vec_nxt_s;

    // One error per sample, whether sum, carry or both disagree with the golden adder.
    function automatic logic ha_mismatch(input logic a, input logic b,
                                         input logic s, input logic c);
        return (s != (a ^ b)) || (c != (a & b));
    endfunction

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_s      = state_r;
        vec_s        = vec_r;
        pass_cnt_s   = pass_cnt_r;
        settle_cnt_s = settle_cnt_r;
        a_s          = a_r;
        b_s          = b_r;
        busy_s       = busy_r;
        done_s       = done_r;
        pass_s       = pass_r;
        err_s        = err_r;
        fail_s       = fail_r;
        mism_s       = 1'b0;
        err_upd_s    = err_r;
        fail_upd_s   = fail_r;
        vec_nxt_s    = vec_r + 2'd1;

        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    err_s        = '0;
                    fail_s       = 4'b0000;
                    pass_s       = 1'b0;
                    done_s       = 1'b0;
                    vec_s        = 2'd0;
                    pass_cnt_s   = '0;
                    settle_cnt_s = '0;
                    a_s          = 1'b0;
                    b_s          = 1'b0;
                    busy_s       = 1'b1;
                    state_s      = SETTLE;
                end else begin
                    state_s = state_r;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    settle_cnt_s = '0;
                    state_s      = SAMPLE;
                end else begin
                    settle_cnt_s = settle_cnt_r + CNT_W'(1);
                end
            end
            SAMPLE: begin
                mism_s = ha_mismatch(a_r, b_r, bus.sum_in, bus.carry_in);
                if (mism_s) begin
                    if (err_r != ERR_MAX) begin
                        err_upd_s = err_r + ERR_W'(1);
                    end else begin
                        err_upd_s = err_r;
                    end
                    fail_upd_s[vec_r] = 1'b1;
                end else begin
                    err_upd_s = err_r;
                end
                err_s  = err_upd_s;
                fail_s = fail_upd_s;

                if ((vec_r == 2'd3) && (pass_cnt_r == PASS_LAST)) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    a_s     = 1'b0;
                    b_s     = 1'b0;
                    pass_s  = (err_upd_s == '0);
                end else begin
                    vec_s = vec_nxt_s;
                    if (vec_r == 2'd3) begin
                        pass_cnt_s = pass_cnt_r + PC_W'(1);
                    end else begin
                        pass_cnt_s = pass_cnt_r;
                    end
                    a_s     = vec_nxt_s[1];
                    b_s     = vec_nxt_s[0];
                    state_s = SETTLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            vec_r        <= 2'd0;
            pass_cnt_r   <= '0;
            settle_cnt_r <= '0;
            a_r          <= 1'b0;
            b_r          <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_r        <= '0;
            fail_r       <= 4'b0000;
        end else begin
            state_r      <= state_s;
            vec_r        <= vec_s;
            pass_cnt_r   <= pass_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            a_r          <= a_s;
            b_r          <= b_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            err_r        <= err_s;
            fail_r       <= fail_s;
        end
    end

    assign bus.a_out     = a_r;
    assign bus.b_out     = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fail_r;

endmodule

// File: tb/tb_ha_selftest.sv
// Bench for ha_selftest: two sequencer configurations, each driving a half-adder
// model whose fault mode is selectable; per-cycle and result scoreboards.
module tb_ha_selftest;

    localparam int S0 = 2;
    localparam int P0 = 1;
    localparam int E0 = 8;
    localparam int S1 = 1;
    localparam int P1 = 2;
    localparam int E1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ha_selftest_if #(.ERR_W(E0)) if0 ();
    ha_selftest_if #(.ERR_W(E1)) if1 ();

    logic [1:0] mode0 = 2'd0;
    logic [1:0] mode1 = 2'd0;
    logic [1:0] resp0, resp1;

    int total  = 0;
    int passed = 0;

    logic [3:0]  cyc_q[$];
    logic [12:0] res_q[$];

    // Half-adder under test: mode 0 good, 1 sum stuck-0, 2 sum=XNOR, 3 both outputs inverted.
    function automatic logic [1:0] ha_resp(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    return {a ^ b, a & b};
            2'd1:    return {1'b0, a & b};
            2'd2:    return {~(a ^ b), a & b};
            default: return {~(a ^ b), ~(a & b)};
        endcase
    endfunction

    assign resp0        = ha_resp(mode0, if0.a_out, if0.b_out);
    assign if0.sum_in   = resp0[1];
    assign if0.carry_in = resp0[0];
    assign resp1        = ha_resp(mode1, if1.a_out, if1.b_out);
    assign if1.sum_in   = resp1[1];
    assign if1.carry_in = resp1[0];

    ha_selftest #(.SETTLE_CYCLES(S0), .PASSES(P0), .ERR_W(E0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master));
    ha_selftest #(.SETTLE_CYCLES(S1), .PASSES(P1), .ERR_W(E1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master));

    // Expected {pass, err_count(8b), fail_vec} after a full run.
    function automatic logic [12:0] model(input logic [1:0] m, input int p, input int ew);
        int err;
        int maxv;
        logic [3:0] fv;
        logic [1:0] r;
        logic a, b;
        err  = 0;
        fv   = 4'b0000;
        maxv = (1 << ew) - 1;
        for (int pp = 0; pp < p; pp++) begin
            for (int v = 0; v < 4; v++) begin
                a = v[1];
                b = v[0];
                r = ha_resp(m, a, b);
                if (r != {a ^ b, a & b}) begin
                    if (err < maxv) err++;
                    fv[v] = 1'b1;
                end
            end
        end
        return {(err == 0), err[7:0], fv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run on dut0 with optional mid-run start pulse and optional mid-run reset.
    task automatic run0(input logic [1:0] m, input int restart_at, input int rst_at);
        int n;
        logic [1:0] v;
        n     = 4 * P0 * (S0 + 1);
        mode0 = m;
        for (int i = 0; i <= n; i++) begin
            v = 2'((i / (S0 + 1)) % 4);
            cyc_q.push_back((i < n) ? {2'b10, v} : 4'b0100);
        end
        res_q.push_back(model(m, P0, E0));
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("cleared", {if0.pass, if0.err_count, if0.fail_vec}, 32'd0);
        for (int i = 0; i <= n; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid", {if0.a_out, if0.b_out, if0.busy, if0.done, if0.pass,
                                if0.err_count, if0.fail_vec}, 32'd0);
                rst_n = 1'b1;
                cyc_q.delete();
                res_q.delete();
                tick();
                chk("rst_idle", {if0.busy, if0.done, if0.a_out, if0.b_out}, 32'd0);
                return;
            end
            chk($sformatf("cyc%0d", i), {if0.busy, if0.done, if0.a_out, if0.b_out},
                cyc_q.pop_front());
            if (i == restart_at) if0.start = 1'b1;
            tick();
            if0.start = 1'b0;
        end
        chk("result", {if0.pass, if0.err_count, if0.fail_vec}, res_q.pop_front());
        tick();
        chk("done_hold", {if0.busy, if0.done}, 32'd1);
    endtask

    // Full run on dut1 checking exact completion time and results.
    task automatic run1(input logic [1:0] m);
        int n;
        n     = 4 * P1 * (S1 + 1);
        mode1 = m;
        res_q.push_back(model(m, P1, E1));
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        repeat (n - 1) tick();
        chk("d1_not_done", {if1.busy, if1.done}, 32'd2);
        tick();
        chk("d1_done", {if1.busy, if1.done, if1.a_out, if1.b_out}, 32'd4);
        chk("d1_result", {if1.pass, 6'd0, if1.err_count, if1.fail_vec}, res_q.pop_front());
    endtask

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        rst_n     = 1'b0;
        repeat (2) tick();
        chk("rst0", {if0.a_out, if0.b_out, if0.busy, if0.done, if0.pass,
                     if0.err_count, if0.fail_vec}, 32'd0);
        chk("rst1", {if1.a_out, if1.b_out, if1.busy, if1.done, if1.pass,
                     if1.err_count, if1.fail_vec}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_hold", {if0.busy, if0.done, if1.busy, if1.done}, 32'd0);

        run0(2'd0, -1, -1);
        chk("plan_good", {if0.pass, if0.err_count, if0.fail_vec}, {19'd0, 1'b1, 8'd0, 4'b0000});
        run0(2'd1, -1, -1);
        chk("plan_stuck", {if0.pass, if0.err_count, if0.fail_vec}, {19'd0, 1'b0, 8'd2, 4'b0110});
        run0(2'd2, -1, -1);
        chk("plan_xnor", {if0.pass, if0.err_count, if0.fail_vec}, {19'd0, 1'b0, 8'd4, 4'b1111});
        run0(2'd3, 5, -1);
        run0(2'd0, 3, -1);
        run0(2'd1, -1, 7);
        run0(2'd0, -1, -1);

        run1(2'd3);
        chk("plan_sat", {if1.pass, if1.err_count, if1.fail_vec}, {25'd0, 1'b0, 2'd3, 4'b1111});
        run1(2'd0);
        run1(2'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
